// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch program counter with stall, redirect, exception vectoring
// and a circular return-address stack. Revision 1.0.
`default_nettype none

module pc_sequencer #(
  parameter int unsigned           WIDTH        = 32,
  parameter int unsigned           STEP         = 4,
  parameter logic [WIDTH-1:0]      RESET_VECTOR = '0,
  parameter logic [31:0]           EXC_VECTOR   = 32'h0000_0080,
  parameter int unsigned           RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             call,
  input  logic             ret,
  input  logic             exception,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus_step,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             misaligned,
  output logic             ret_underflow
);

  localparam int unsigned    PW         = $clog2(RAS_DEPTH);
  localparam int unsigned    CW         = PW + 1;
  localparam logic [WIDTH-1:0] C_STEP   = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] C_MASK   = WIDTH'(STEP - 1);
  localparam logic [WIDTH-1:0] C_EXC    = WIDTH'(EXC_VECTOR);
  localparam logic [CW-1:0]  C_DEPTH    = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic             misaligned_q, misaligned_d;
  logic             underflow_q, underflow_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];

  logic             ras_we;
  logic [PW-1:0]    ras_widx;
  logic             full_w;

  assign pc_plus_step  = pc_q + C_STEP;
  assign full_w        = (cnt_q == C_DEPTH);
  assign pc            = pc_q;
  assign ras_empty     = (cnt_q == '0);
  assign ras_full      = full_w;
  assign misaligned    = misaligned_q;
  assign ret_underflow = underflow_q;

  always_comb begin
    pc_d         = pc_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    misaligned_d = 1'b0;
    underflow_d  = 1'b0;
    ras_we       = 1'b0;
    ras_widx     = ptr_q;
    if (en) begin
      if (exception) begin
        pc_d = C_EXC;
      end else if (redirect_valid) begin
        pc_d         = redirect_target & ~C_MASK;
        misaligned_d = |(redirect_target & C_MASK);
        if (call) begin
          // Pushing onto a full stack silently drops the oldest entry.
          ptr_d    = ptr_q + 1'b1;
          ras_widx = ptr_q + 1'b1;
          ras_we   = 1'b1;
          cnt_d    = full_w ? cnt_q : cnt_q + 1'b1;
        end
      end else if (ret) begin
        if (cnt_q != '0) begin
          pc_d = ras_q[ptr_q];
          if (call) begin
            ras_we = 1'b1;
          end else begin
            ptr_d = ptr_q - 1'b1;
            cnt_d = cnt_q - 1'b1;
          end
        end else begin
          underflow_d = 1'b1;
        end
      end else if (!stall) begin
        pc_d = pc_plus_step;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q         <= RESET_VECTOR;
      cnt_q        <= '0;
      ptr_q        <= '0;
      misaligned_q <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      misaligned_q <= misaligned_d;
      underflow_q  <= underflow_d;
    end
  end

  // Stack contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (ras_we) begin
      ras_q[ras_widx] <= pc_plus_step;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed table-driven checks of pc_sequencer (32-bit default
// instance) plus hand sequences for wrap (8-bit instance) and async reset.
`default_nettype none

module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        en, stall, rv, call, ret, exc;
  logic [31:0] tgt;

  logic [31:0] pc, pps;
  logic        emp, full, mis, und;
  logic [7:0]  pc8, pps8;
  logic        emp8, full8, mis8, und8;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  pc_sequencer u_dut (
    .clk(clk), .reset(reset), .en(en), .stall(stall),
    .redirect_valid(rv), .redirect_target(tgt), .call(call), .ret(ret),
    .exception(exc), .pc(pc), .pc_plus_step(pps), .ras_empty(emp),
    .ras_full(full), .misaligned(mis), .ret_underflow(und)
  );

  pc_sequencer #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .en(en), .stall(stall),
    .redirect_valid(rv), .redirect_target(tgt[7:0]), .call(call), .ret(ret),
    .exception(exc), .pc(pc8), .pc_plus_step(pps8), .ras_empty(emp8),
    .ras_full(full8), .misaligned(mis8), .ret_underflow(und8)
  );

  typedef struct {
    logic        en, stall, rv, call, ret, exc;
    logic [31:0] tgt;
    logic [31:0] pc;
    logic        emp, full, mis, und;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic e, input logic s, input logic r,
                              input logic c, input logic rt, input logic x,
                              input logic [31:0] t, input logic [31:0] p,
                              input logic em, input logic fu, input logic mi,
                              input logic un);
    vec_t v;
    v.en = e; v.stall = s; v.rv = r; v.call = c; v.ret = rt; v.exc = x;
    v.tgt = t; v.pc = p; v.emp = em; v.full = fu; v.mis = mi; v.und = un;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic idle();
    en = 1'b1; stall = 1'b0; rv = 1'b0; call = 1'b0; ret = 1'b0; exc = 1'b0; tgt = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //           en s  rv c  rt x  target        pc            emp fu mi un
    vecs.push_back(mk(1,0,0,0,0,0, 32'h0,        32'h4,        1,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0, 32'h0,        32'h8,        1,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0, 32'h0,        32'hC,        1,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0, 32'h0,        32'h10,       1,0,0,0));
    vecs.push_back(mk(1,0,1,1,0,0, 32'h203,      32'h200,      0,0,1,0));
    vecs.push_back(mk(1,0,0,0,1,0, 32'h0,        32'h14,       1,0,0,0));
    vecs.push_back(mk(1,0,1,1,0,0, 32'h1000,     32'h1000,     0,0,0,0));
    vecs.push_back(mk(1,0,1,1,0,0, 32'h2000,     32'h2000,     0,0,0,0));
    vecs.push_back(mk(1,0,1,1,0,0, 32'h3000,     32'h3000,     0,0,0,0));
    vecs.push_back(mk(1,0,1,1,0,0, 32'h4000,     32'h4000,     0,1,0,0));
    vecs.push_back(mk(1,0,1,1,0,0, 32'h5000,     32'h5000,     0,1,0,0));
    vecs.push_back(mk(1,0,0,0,1,0, 32'h0,        32'h4004,     0,0,0,0));
    vecs.push_back(mk(1,0,0,0,1,0, 32'h0,        32'h3004,     0,0,0,0));
    vecs.push_back(mk(1,0,0,0,1,0, 32'h0,        32'h2004,     0,0,0,0));
    vecs.push_back(mk(1,0,0,0,1,0, 32'h0,        32'h1004,     1,0,0,0));
    vecs.push_back(mk(1,0,0,0,1,0, 32'h0,        32'h1004,     1,0,0,1));
    vecs.push_back(mk(1,0,0,0,0,0, 32'h0,        32'h1008,     1,0,0,0));
    vecs.push_back(mk(1,0,1,1,0,0, 32'h600,      32'h600,      0,0,0,0));
    vecs.push_back(mk(1,0,1,0,1,1, 32'h700,      32'h80,       0,0,0,0));
    vecs.push_back(mk(1,0,1,0,1,0, 32'h700,      32'h700,      0,0,0,0));
    vecs.push_back(mk(1,0,0,0,1,0, 32'h0,        32'h100C,     1,0,0,0));
    vecs.push_back(mk(1,0,1,0,0,0, 32'h3C,       32'h3C,       1,0,0,0));
    vecs.push_back(mk(1,0,1,1,0,0, 32'h100,      32'h100,      0,0,0,0));
    vecs.push_back(mk(1,0,0,1,1,0, 32'h0,        32'h40,       0,0,0,0));
    vecs.push_back(mk(1,0,0,0,1,0, 32'h0,        32'h104,      1,0,0,0));
    vecs.push_back(mk(1,1,0,0,0,0, 32'h0,        32'h104,      1,0,0,0));
    vecs.push_back(mk(0,0,1,0,0,0, 32'h900,      32'h104,      1,0,0,0));
    vecs.push_back(mk(1,0,0,1,0,0, 32'h0,        32'h108,      1,0,0,0));
    vecs.push_back(mk(1,1,0,1,0,0, 32'h0,        32'h108,      1,0,0,0));
    vecs.push_back(mk(1,0,1,0,0,0, 32'h201,      32'h200,      1,0,1,0));
    vecs.push_back(mk(0,0,0,0,0,0, 32'h0,        32'h200,      1,0,0,0));

    idle();
    reset = 1'b0;
    #2;
    check("rst.pc", pc, 32'h0);
    check("rst.empty", 32'(emp), 32'h1);
    check("rst.full", 32'(full), 32'h0);
    check("rst.mis", 32'(mis), 32'h0);
    check("rst.und", 32'(und), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      en = vecs[i].en; stall = vecs[i].stall; rv = vecs[i].rv;
      call = vecs[i].call; ret = vecs[i].ret; exc = vecs[i].exc; tgt = vecs[i].tgt;
      @(posedge clk);
      #1;
      check($sformatf("v%0d.pc", i), pc, vecs[i].pc);
      check($sformatf("v%0d.pps", i), pps, vecs[i].pc + 32'd4);
      check($sformatf("v%0d.empty", i), 32'(emp), 32'(vecs[i].emp));
      check($sformatf("v%0d.full", i), 32'(full), 32'(vecs[i].full));
      check($sformatf("v%0d.mis", i), 32'(mis), 32'(vecs[i].mis));
      check($sformatf("v%0d.und", i), 32'(und), 32'(vecs[i].und));
    end

    // 8-bit wrap, stall and disabled redirect on the narrow instance
    idle(); rv = 1'b1; tgt = 32'hF8;
    @(posedge clk); #1;
    check("w8.pc_f8", 32'(pc8), 32'hF8);
    idle();
    @(posedge clk); #1;
    check("w8.pc_fc", 32'(pc8), 32'hFC);
    check("w8.pps_wrap", 32'(pps8), 32'h00);
    @(posedge clk); #1;
    check("w8.pc_wrap", 32'(pc8), 32'h00);
    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check($sformatf("w8.stall%0d", k), 32'(pc8), 32'h00);
    end
    idle(); en = 1'b0; rv = 1'b1; tgt = 32'h40;
    @(posedge clk); #1;
    check("w8.en0", 32'(pc8), 32'h00);

    // Asynchronous reset between edges with stack and pulse live
    idle(); rv = 1'b1; call = 1'b1; tgt = 32'h203;
    @(posedge clk); #1;
    check("ar.pre_mis", 32'(mis), 32'h1);
    check("ar.pre_empty", 32'(emp), 32'h0);
    idle();
    #2;
    reset = 1'b0;
    #1;
    check("ar.pc", pc, 32'h0);
    check("ar.empty", 32'(emp), 32'h1);
    check("ar.mis", 32'(mis), 32'h0);
    check("ar.pc8", 32'(pc8), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("ar.post_pc", pc, 32'h4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter sequencer; successor to the fixed 32-bit instruction incrementer. Holds the fetch PC and advances it by a configurable step each enabled cycle. Also supports stall, branch/jump redirect, exception vectoring and a circular return-address stack (RAS) for call/return. Sits at the head of the fetch stage and drives the instruction memory address.

Parameters:
WIDTH, 32, PC width in bits.
STEP, 4, sequential increment in bytes; power of two, 1..2^(WIDTH-1).
RESET_VECTOR, 0, PC value loaded by reset.
EXC_VECTOR, 32'h0000_0080, PC value loaded on exception (truncated to WIDTH).
RAS_DEPTH, 4, return-address stack entries; power of two, 2..16.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
en  input  1  global advance enable; 0 freezes all state.
stall  input  1  hold PC this cycle.
redirect_valid  input  1  load redirect_target (branch/jump taken).
redirect_target  input  WIDTH  redirect destination.
call  input  1  push pc+STEP onto the RAS; qualifies redirect_valid or ret.
ret  input  1  pop the RAS and load the popped address.
exception  input  1  load EXC_VECTOR.
pc  output  WIDTH  current fetch address, registered.
pc_plus_step  output  WIDTH  combinational pc+STEP mod 2^WIDTH (link value).
ras_empty  output  1  RAS count == 0.
ras_full  output  1  RAS count == RAS_DEPTH.
misaligned  output  1  registered one-cycle pulse: accepted redirect target was not STEP-aligned.
ret_underflow  output  1  registered one-cycle pulse: ret accepted while RAS empty.

Behaviour:
- Reset (reset==0, async): pc=RESET_VECTOR, RAS count=0, top pointer=0, misaligned=0, ret_underflow=0. RAS entry contents are don't-care. ras_empty=1 and ras_full=0 immediately. Reset mid-operation discards any pending update.
- en==0: all registers hold. Pulse outputs clear to 0 on the next edge.
- en==1: the next pc is chosen by strict priority. The selected source is visible on pc one cycle after the edge.
  1. exception: pc<=EXC_VECTOR. RAS untouched; call and ret ignored.
  2. redirect_valid: pc<=redirect_target with the low log2(STEP) bits cleared. misaligned<=1 if any of those bits were set. If call==1, push pc_plus_step. A concurrent ret is ignored.
  3. ret: if RAS non-empty, pc<=RAS[top] and pop. If RAS empty, pc holds and ret_underflow<=1. If call==1 as well, the popped entry is replaced by the current pc_plus_step; count and pointer are unchanged (swap).
  4. stall: pc holds. A call without a redirect is ignored.
  5. otherwise: pc<=pc_plus_step (wraps modulo 2^WIDTH). A call without a redirect is ignored.
- RAS is circular. A push when full overwrites the oldest entry: pointer advances, count saturates at RAS_DEPTH. A pop decrements count and pointer modulo RAS_DEPTH.
- Pulse outputs are 1 for exactly the cycle following the causing edge, then return to 0.
- Latency: one clock from input to pc for every source. pc_plus_step has zero latency relative to pc.

Test Plan:
1. Reset release with RESET_VECTOR=0 and en=1 for 4 cycles -> pc=0,4,8,12,16. Assert reset asynchronously between edges -> pc=0 immediately.
2. WIDTH=8, STEP=4, pc reaches 8'hFC, en=1 -> next pc=8'h00. stall=1 for 2 cycles -> pc holds at 8'h00. en=0 with redirect_valid=1 -> pc unchanged.
3. pc=0x10, redirect_valid=1, call=1, target=0x203 -> pc=0x200, misaligned pulses 1 cycle, RAS top=0x14. Then ret=1 -> pc=0x14, ras_empty=1.
4. RAS_DEPTH=4: five call+redirect cycles pushing A1..A5 -> ras_full=1. Four rets return A5,A4,A3,A2 (A1 overwritten). A fifth ret -> pc holds, ret_underflow=1.
5. Same edge: exception=1, redirect_valid=1, ret=1, with RAS holding one entry -> pc=EXC_VECTOR, RAS count still 1. Next cycle redirect+ret -> redirect target taken, RAS count still 1.
6. RAS top=0x40, pc=0x100, call=1 and ret=1 together -> pc=0x40, RAS top=0x104, count unchanged.
